fetch_queue: RTL and testbench
==============================

# fetch_queue

Parametrised instruction-fetch stage for the MIPS datapath. It owns the program counter, issues addresses to the combinational instruction memory, and buffers fetched instructions with their PC in a DEPTH-entry FIFO. Decode drains it through a valid/ready handshake. Branch redirects compute the target internally, flush the queue, and restart fetch at the target.

## Interface
- PC_WIDTH, 5: program-counter width in bits; minimum 3; all PC arithmetic is modulo 2^PC_WIDTH.
- DEPTH, 4: FIFO entries; power of two, at least 2.
- RESET_PC, 0: PC loaded on reset; low two bits must be 0.

- clk  in  1  clock; every register updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- imem_addr  out  PC_WIDTH  fetch address, equal to fetch_pc.
- imem_rdata  in  32  instruction at imem_addr, valid in the same cycle.
- redirect_valid  in  1  branch taken this cycle.
- redirect_base  in  PC_WIDTH  PC of the branch instruction.
- redirect_imm  in  16  branch immediate, signed, in words.
- instr_valid  out  1  head entry valid.
- instr_ready  in  1  decode accepts the head entry this cycle.
- instr  out  32  head instruction.
- instr_pc  out  PC_WIDTH  PC of the head instruction.
- instr_pc_plus4  out  PC_WIDTH  instr_pc + 4, modulo 2^PC_WIDTH.
- count  out  clog2(DEPTH)+1  current occupancy.

## Operation
- State:
  - fetch_pc register.
  - Circular buffer storage[DEPTH] of {instr, pc}.
  - wr_ptr and rd_ptr, each clog2(DEPTH) bits, wrapping naturally.
  - count register.
- pop = instr_valid & instr_ready.
- push = !redirect_valid & (count < DEPTH | pop).
  - A full queue with a simultaneous pop still pushes, so throughput is sustained at 1 instruction per cycle.
- On push:
  - storage[wr_ptr] <= {imem_rdata, fetch_pc}.
  - wr_ptr increments.
  - fetch_pc <= fetch_pc + 4, wrapping.
- On pop, rd_ptr increments.
- count update:
  - push only: +1.
  - pop only: −1.
  - push and pop: unchanged.
- Redirect (redirect_valid=1):
  - target = (redirect_base + 4 + (sext(redirect_imm) << 2)) truncated to PC_WIDTH, with the low 2 bits forced to 0.
  - fetch_pc <= target.
  - count, wr_ptr and rd_ptr are all cleared to 0.
  - No push occurs that cycle.
  - A pop asserted in the same cycle still counts as accepted by decode; the queue is cleared regardless.
- Priority: rst > redirect_valid > push/pop.
- Outputs are driven from storage[rd_ptr].
  - instr_valid = (count != 0).
  - instr and instr_pc are don't-care when instr_valid=0.
- Stall: while instr_ready=0 with count=DEPTH:
  - fetch_pc holds.
  - imem_addr holds.
  - The head entry is stable.

## Timing
- Reset values:
  - fetch_pc = RESET_PC, so imem_addr = RESET_PC.
  - count = 0, instr_valid = 0.
  - Both pointers = 0.
  - instr, instr_pc and instr_pc_plus4 are unspecified (storage is not reset).
- Reset applies at any time, including during a redirect or a full stall.
  - Storage contents are abandoned.
  - The cycle after rst deasserts is the first fetch of RESET_PC.
- Fetch-to-valid latency is 1 cycle: an instruction pushed at edge N is visible as the head after edge N if the queue was empty.
- Redirect-to-valid latency is 2 edges:
  - The redirect edge loads the target.
  - The next edge pushes the target instruction.
  - instr_valid is 0 for exactly the one cycle between those edges.
- Back-to-back redirects: each redirect reloads fetch_pc and re-flushes; the last one wins.
- Wrap-around:
  - fetch_pc wraps from 2^PC_WIDTH−4 to 0.
  - The target computation wraps silently, with no error flag.

## Test plan
- Reset, then instr_ready=1 held, imem returning 0x8C000000 | addr:
  - instr_valid rises 1 cycle after rst falls.
  - instr_pc sequence is 0,4,8,...,28,0 (PC_WIDTH=5).
  - instr_pc_plus4 = instr_pc+4 modulo 32.
- instr_ready=0 from reset:
  - count reaches 4 after 4 cycles and holds.
  - imem_addr stays 16.
  - Then instr_ready=1: the head reads 0,4,8,12,16 in order with no gaps.
- Full queue with instr_ready=1 for one cycle: count stays 4 and imem_addr advances 16→20 (simultaneous push/pop).
- redirect_valid with base=8, imm=0x0003: next imem_addr=24, count=0, and the next valid instr_pc=24.
- Negative immediate: base=4, imm=0xFFFE gives target 0.
- Wrap: base=28, imm=0x0001 gives target 4 (PC_WIDTH=5).
- rst asserted with count=3 and redirect_valid=1 in the same cycle:
  - Next cycle: count=0, imem_addr=RESET_PC, instr_valid=0.
  - The redirect target is ignored.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch stage for the MIPS datapath.
//
// Owns the program counter, presents it to a combinational instruction
// memory, and buffers each fetched instruction together with its PC in a
// DEPTH-entry circular FIFO. Decode drains the FIFO through a valid/ready
// handshake. A taken branch computes its target here, flushes the queue and
// restarts fetch at the target.
//
// Parameters
//   PC_WIDTH  program-counter width (>= 3); PC arithmetic wraps mod 2^PC_WIDTH
//   DEPTH     FIFO entries (power of two, >= 2)
//   RESET_PC  PC loaded on reset (word aligned)
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   imem_addr        fetch address (equals the fetch PC)
//   imem_rdata       instruction at imem_addr, same cycle
//   redirect_valid   branch taken this cycle
//   redirect_base    PC of the branch instruction
//   redirect_imm     signed word offset of the branch
//   instr_valid      head entry valid
//   instr_ready      decode accepts the head entry
//   instr, instr_pc  head instruction and its PC
//   instr_pc_plus4   instr_pc + 4 (wrapping)
//   count            current occupancy
module fetch_queue #(
  parameter int PC_WIDTH = 5,
  parameter int DEPTH    = 4,
  parameter int RESET_PC = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [PC_WIDTH-1:0]        imem_addr,
  input  logic [31:0]                imem_rdata,
  input  logic                       redirect_valid,
  input  logic [PC_WIDTH-1:0]        redirect_base,
  input  logic [15:0]                redirect_imm,
  output logic                       instr_valid,
  input  logic                       instr_ready,
  output logic [31:0]                instr,
  output logic [PC_WIDTH-1:0]        instr_pc,
  output logic [PC_WIDTH-1:0]        instr_pc_plus4,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Branch target: base + 4 + (imm << 2), wrapped to PC_WIDTH and forced
  // word aligned. The byte offset is truncated before the add; since all
  // arithmetic is modulo 2^PC_WIDTH this gives the same result.
  function automatic logic [PC_WIDTH-1:0] branch_target(
    input logic [PC_WIDTH-1:0] base,
    input logic signed [15:0]  imm
  );
    logic signed [31:0]  byte_off;
    logic [PC_WIDTH-1:0] sum;
    byte_off = 32'(imm) <<< 2;
    sum      = base + PC_WIDTH'(4) + PC_WIDTH'(byte_off);
    return {sum[PC_WIDTH-1:2], 2'b00};
  endfunction

  logic [PC_WIDTH-1:0] fetch_pc;
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    cnt;

  logic [31:0]         instr_mem [DEPTH];
  logic [PC_WIDTH-1:0] pc_mem    [DEPTH];

  logic                push;
  logic                pop;
  logic [PC_WIDTH-1:0] target;

  assign instr_valid = (cnt != '0);
  assign pop         = instr_valid & instr_ready;
  // A full queue that is popping this cycle frees a slot for this cycle's
  // fetch, keeping one instruction per cycle flowing.
  assign push        = !redirect_valid & ((cnt < CNT_W'(DEPTH)) | pop);
  assign target      = branch_target(redirect_base, $signed(redirect_imm));

  // Control state: PC, pointers, occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= PC_WIDTH'(RESET_PC);
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
    end else if (redirect_valid) begin
      // Flush regardless of a same-cycle pop; decode still saw its accept.
      fetch_pc <= target;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + PTR_W'(1);
        fetch_pc <= fetch_pc + PC_WIDTH'(4);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Data storage: not reset; entries are only read once counted valid
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr]    <= fetch_pc;
    end
  end

  assign imem_addr      = fetch_pc;
  assign instr          = instr_mem[rd_ptr];
  assign instr_pc       = pc_mem[rd_ptr];
  assign instr_pc_plus4 = pc_mem[rd_ptr] + PC_WIDTH'(4);
  assign count          = cnt;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (PC_WIDTH=5, DEPTH=4, RESET_PC=0).
// The instruction memory model returns 0x8C000000 | addr.
module tb_fetch_queue;

  localparam int PC_WIDTH = 5;
  localparam int DEPTH    = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [PC_WIDTH-1:0] imem_addr;
  logic [31:0]         imem_rdata;
  logic                redirect_valid;
  logic [PC_WIDTH-1:0] redirect_base;
  logic [15:0]         redirect_imm;
  logic                instr_valid;
  logic                instr_ready;
  logic [31:0]         instr;
  logic [PC_WIDTH-1:0] instr_pc;
  logic [PC_WIDTH-1:0] instr_pc_plus4;
  logic [2:0]          count;

  int n_cmp = 0;
  int n_err = 0;

  fetch_queue #(.PC_WIDTH(PC_WIDTH), .DEPTH(DEPTH), .RESET_PC(0)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_base  (redirect_base),
    .redirect_imm   (redirect_imm),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_pc_plus4 (instr_pc_plus4),
    .count          (count)
  );

  always #5 clk = ~clk;

  assign imem_rdata = 32'h8C00_0000 | 32'(imem_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [PC_WIDTH-1:0] base, input logic [15:0] imm);
    redirect_valid = 1'b1;
    redirect_base  = base;
    redirect_imm   = imm;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_base  = '0;
    redirect_imm   = '0;
    instr_ready    = 1'b1;
    tick();
    tick();
    check("rst_count", 32'(count), 0);
    check("rst_valid", 32'(instr_valid), 0);
    check("rst_addr", 32'(imem_addr), 0);

    // Streaming with decode always ready: one instruction per cycle, PC wraps.
    rst = 1'b0;
    tick();
    for (int i = 0; i < 9; i++) begin
      check("stream_valid", 32'(instr_valid), 1);
      check("stream_pc", 32'(instr_pc), (4 * i) % 32);
      check("stream_instr", instr, 32'h8C00_0000 | ((4 * i) % 32));
      check("stream_pc4", 32'(instr_pc_plus4), (4 * i + 4) % 32);
      check("stream_count", 32'(count), 1);
      tick();
    end

    // Stall from reset: fill to DEPTH and hold.
    rst         = 1'b1;
    instr_ready = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("fill_count", 32'(count), i);
    end
    check("fill_addr", 32'(imem_addr), 16);
    tick();
    tick();
    check("stall_count", 32'(count), 4);
    check("stall_addr", 32'(imem_addr), 16);
    check("stall_head_pc", 32'(instr_pc), 0);
    check("stall_head", instr, 32'h8C00_0000);

    // Full with a pop: simultaneous push/pop keeps count at DEPTH.
    instr_ready = 1'b1;
    tick();
    check("fullpop_count", 32'(count), 4);
    check("fullpop_addr", 32'(imem_addr), 20);
    for (int i = 1; i <= 5; i++) begin
      check("drain_valid", 32'(instr_valid), 1);
      check("drain_pc", 32'(instr_pc), 4 * i);
      tick();
    end

    // Redirect with decode popping in the same cycle: 8 + 4 + 12 = 24.
    redirect(5'd8, 16'h0003);
    check("redir_addr", 32'(imem_addr), 24);
    check("redir_count", 32'(count), 0);
    check("redir_valid", 32'(instr_valid), 0);
    tick();
    check("redir_valid2", 32'(instr_valid), 1);
    check("redir_pc", 32'(instr_pc), 24);
    check("redir_instr", instr, 32'h8C00_0018);

    // Negative immediate: 4 + 4 - 8 = 0.
    redirect(5'd4, 16'hFFFE);
    check("neg_addr", 32'(imem_addr), 0);
    check("neg_count", 32'(count), 0);

    // Target wraps: 28 + 4 + 4 = 36 -> 4.
    redirect(5'd28, 16'h0001);
    check("wrap_addr", 32'(imem_addr), 4);

    // Unaligned base: 9 + 4 = 13, low bits cleared -> 12.
    redirect(5'd9, 16'h0000);
    check("align_addr", 32'(imem_addr), 12);

    // Back-to-back redirects: the last one wins.
    redirect(5'd8, 16'h0003);
    redirect(5'd4, 16'hFFFE);
    check("b2b_addr", 32'(imem_addr), 0);
    check("b2b_valid", 32'(instr_valid), 0);
    tick();
    check("b2b_pc", 32'(instr_pc), 0);
    check("b2b_count", 32'(count), 1);

    // Reset beats a same-cycle redirect with three entries queued.
    instr_ready = 1'b0;
    redirect(5'd16, 16'h0000);
    check("pre_addr", 32'(imem_addr), 20);
    tick();
    tick();
    tick();
    check("pre_count", 32'(count), 3);
    rst            = 1'b1;
    redirect_valid = 1'b1;
    redirect_base  = 5'd8;
    redirect_imm   = 16'h0003;
    tick();
    rst            = 1'b0;
    redirect_valid = 1'b0;
    check("rstred_count", 32'(count), 0);
    check("rstred_addr", 32'(imem_addr), 0);
    check("rstred_valid", 32'(instr_valid), 0);
    instr_ready = 1'b1;
    tick();
    check("rstred_pc", 32'(instr_pc), 0);
    check("rstred_valid2", 32'(instr_valid), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
